// File: rtl/hiscore_ram_arbiter_if.sv
// Signal bundle between the CPU / hiscore engine side and the hiscore RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface hiscore_ram_arbiter_if #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_cs;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_we;
    logic              cpu_wait;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_data;
    logic              hs_write;
    logic              hs_upload;
    logic [DATA_W-1:0] hs_din;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    modport slave (
        input  cpu_cs, cpu_addr, cpu_dout, cpu_we,
        input  hs_addr, hs_data, hs_write, hs_upload,
        input  ram_dout,
        output cpu_wait, hs_din,
        output ram_addr, ram_din, ram_we,
        output fifo_level, overflow
    );

    modport master (
        output cpu_cs, cpu_addr, cpu_dout, cpu_we,
        output hs_addr, hs_data, hs_write, hs_upload,
        output ram_dout,
        input  cpu_wait, hs_din,
        input  ram_addr, ram_din, ram_we,
        input  fifo_level, overflow
    );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the CPU and the hiscore engine: restore writes are
// queued and retired in CPU-free cycles (or forced after a starvation timeout); upload reads use idle slots.
module hiscore_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8,
    parameter int READ_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    hiscore_ram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        GNT_IDLE,
        GNT_STALL,
        GNT_CPU,
        GNT_WRITE,
        GNT_READ
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              r_mem [FIFO_DEPTH];
    logic [PTR_W:0]      r_wptr;
    logic [PTR_W:0]      r_rptr;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [READ_LAT-1:0] r_rd_pipe;
    logic [DATA_W-1:0]   r_hs_din;
    logic                r_overflow;

    grant_e w_grant;
    entry_t w_head;
    logic   w_empty;
    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic   w_read;
    logic   w_drop;

    // The extra pointer MSB tells a full queue (MSBs differ) from an empty one (MSBs equal).
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_head  = r_mem[r_rptr[PTR_W-1:0]];

    always_comb begin
        w_grant = GNT_IDLE;
        if (!w_empty && r_wait_cnt == WAIT_MAX) begin
            w_grant = GNT_STALL;
        end else if (bus.cpu_cs) begin
            w_grant = GNT_CPU;
        end else if (!w_empty) begin
            w_grant = GNT_WRITE;
        end else if (bus.hs_upload) begin
            w_grant = GNT_READ;
        end
    end

    assign w_pop  = reset_n && (w_grant == GNT_STALL || w_grant == GNT_WRITE);
    assign w_read = reset_n && (w_grant == GNT_READ);
    // A full queue still accepts a request in a cycle that also retires its head.
    assign w_push = reset_n && bus.hs_write && (!w_full || w_pop);
    assign w_drop = bus.hs_write && w_full && !w_pop;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        bus.ram_addr = bus.cpu_addr;
        bus.ram_din  = bus.cpu_dout;
        bus.ram_we   = 1'b0;
        bus.cpu_wait = 1'b0;
        unique case (w_grant)
            GNT_STALL: begin
                bus.ram_addr = w_head.addr;
                bus.ram_din  = w_head.data;
                bus.ram_we   = 1'b1;
                bus.cpu_wait = 1'b1;
            end
            GNT_CPU: begin
                bus.ram_we = bus.cpu_we;
            end
            GNT_WRITE: begin
                bus.ram_addr = w_head.addr;
                bus.ram_din  = w_head.data;
                bus.ram_we   = 1'b1;
            end
            GNT_READ: begin
                bus.ram_addr = bus.hs_addr;
            end
            default: ;
        endcase
        if (!reset_n) begin
            bus.ram_we   = 1'b0;
            bus.cpu_wait = 1'b0;
        end
    end

    // NOTE: the queue storage is not reset; clearing the pointers is enough to make it read as empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= '{addr: bus.hs_addr, data: bus.hs_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wait_cnt <= '0;
            r_rd_pipe  <= '0;
            r_hs_din   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop || w_empty) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + CNT_ONE;
            end
            // Read slot marks travel READ_LAT stages so capture lines up with the RAM's data.
            r_rd_pipe <= (r_rd_pipe << 1) | READ_LAT'(w_read);
            if (r_rd_pipe[READ_LAT-1]) begin
                r_hs_din <= bus.ram_dout;
            end
        end
    end

    assign bus.hs_din     = r_hs_din;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = r_wptr - r_rptr;
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based model of the arbitration rules.
module tb_hiscore_ram_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_WAIT   = 8;
    localparam int READ_LAT   = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hiscore_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    hiscore_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_WAIT(MAX_WAIT), .READ_LAT(READ_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Environment RAM: synchronous write, read data appears READ_LAT clocks after the address.
    logic [DATA_W-1:0] ram_mem [2**ADDR_W];
    logic [DATA_W-1:0] ram_rd  [READ_LAT];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) ram_mem[pre_addr] <= pre_data;
        else if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        ram_rd[0] <= ram_mem[bus.ram_addr];
        for (int i = 1; i < READ_LAT; i++) ram_rd[i] <= ram_rd[i-1];
    end
    assign bus.ram_dout = ram_rd[READ_LAT-1];

    // Reference model state.
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct { int due; logic [DATA_W-1:0] val; } rd_t;
    wr_t               m_q [$];
    rd_t               m_rd [$];
    logic [DATA_W-1:0] m_mem [2**ADDR_W];
    int                m_wait = 0;
    bit                m_ovf = 1'b0;
    logic [DATA_W-1:0] m_hs_din = '0;
    int                cyc = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_stall_seen = 0;
    int n_write_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit cs, input bit we, input int caddr, input int cdout,
                         input bit hw, input int haddr, input int hdata, input bit up);
        bus.cpu_cs    = cs;
        bus.cpu_we    = we;
        bus.cpu_addr  = ADDR_W'(caddr);
        bus.cpu_dout  = DATA_W'(cdout);
        bus.hs_write  = hw;
        bus.hs_addr   = ADDR_W'(haddr);
        bus.hs_data   = DATA_W'(hdata);
        bus.hs_upload = up;
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        bit ne, stall, pop, cpu_g, rd_g, exp_we, exp_wait, acc;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        @(negedge clk);
        ne    = (m_q.size() > 0);
        stall = ne && (m_wait == MAX_WAIT);
        cpu_g = !stall && bus.cpu_cs;
        pop   = stall || (!bus.cpu_cs && ne);
        rd_g  = !stall && !bus.cpu_cs && !ne && bus.hs_upload;
        ea = bus.cpu_addr;
        ed = bus.cpu_dout;
        exp_we = 1'b0;
        if (pop) begin
            ea = m_q[0].addr;
            ed = m_q[0].data;
            exp_we = 1'b1;
        end else if (cpu_g) begin
            exp_we = bus.cpu_we;
        end else if (rd_g) begin
            ea = bus.hs_addr;
        end
        exp_wait = stall;
        if (!reset_n) begin
            exp_we = 1'b0;
            exp_wait = 1'b0;
        end
        check("ram_we", 32'(bus.ram_we), 32'(exp_we));
        check("cpu_wait", 32'(bus.cpu_wait), 32'(exp_wait));
        if (reset_n) check("ram_addr", 32'(bus.ram_addr), 32'(ea));
        if (reset_n && exp_we) check("ram_din", 32'(bus.ram_din), 32'(ed));
        check("fifo_level", 32'(bus.fifo_level), 32'(m_q.size()));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("hs_din", 32'(bus.hs_din), 32'(m_hs_din));
        if (bus.cpu_wait) n_stall_seen++;
        if (bus.ram_we) n_write_seen++;

        if (!reset_n) begin
            m_q.delete();
            m_rd.delete();
            m_wait = 0;
            m_ovf = 1'b0;
            m_hs_din = '0;
        end else begin
            while (m_rd.size() > 0 && m_rd[0].due == cyc) begin
                m_hs_din = m_rd[0].val;
                void'(m_rd.pop_front());
            end
            if (rd_g) m_rd.push_back('{due: cyc + READ_LAT, val: m_mem[bus.hs_addr]});
            acc = bus.hs_write && (m_q.size() < FIFO_DEPTH || pop);
            if (bus.hs_write && !acc) m_ovf = 1'b1;
            if (pop) begin
                m_mem[ea] = ed;
                void'(m_q.pop_front());
            end else if (cpu_g && bus.cpu_we) begin
                m_mem[bus.cpu_addr] = bus.cpu_dout;
            end
            if (acc) m_q.push_back('{addr: bus.hs_addr, data: bus.hs_data});
            if (pop || !ne) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int w0, s0;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Preload RAM (and the model's copy) while the DUT is held in reset.
        for (int i = 0; i < 2**ADDR_W; i++) begin
            pre_we   = 1'b1;
            pre_addr = ADDR_W'(i);
            pre_data = (i == 'h023) ? 8'h3C : DATA_W'(i * 7 + 3);
            m_mem[i] = pre_data;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        // Reset state.
        tick();
        reset_n = 1'b1;
        tick();

        // Idle retire: three pushes, each written back the following cycle.
        w0 = n_write_seen;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 'h3F0, 0, 1, 'h010 + i, 'hA1 + i, 0);
            tick();
        end
        drive(0, 0, 'h3F0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("idle_writes", 32'(n_write_seen - w0), 32'd3);

        // Contention: CPU owns the port for five cycles, queued writes follow back-to-back.
        s0 = n_stall_seen;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 'h200 + i, 0, i < 2, 'h010 + i, 'hA1 + i, 0);
            tick();
        end
        drive(0, 0, 'h3F0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("contention_no_stall", 32'(n_stall_seen - s0), 32'd0);

        // Overflow: five pushes into a four-entry queue while the CPU holds the port.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 'h210, 0, 1, 'h030 + i, 'hB0 + i, 0);
            tick();
        end
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("ovf_level", 32'(bus.fifo_level), 32'd4);
        w0 = n_write_seen;
        drive(0, 0, 'h3F0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        check("ovf_writes", 32'(n_write_seen - w0), 32'd4);

        // Starvation: CPU never lets go; one forced write after MAX_WAIT blocked cycles.
        s0 = n_stall_seen;
        drive(1, 1, 'h100, 'h55, 1, 'h040, 'hC4, 0);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(1, 1, 'h100 + i, 'h60 + i, 0, 0, 0, 0);
            tick();
        end
        check("starve_stalls", 32'(n_stall_seen - s0), 32'd1);

        // Upload read of a preloaded location, then one delayed by CPU traffic.
        drive(0, 0, 'h3F0, 0, 0, 'h023, 0, 1);
        tick();
        tick();
        check("upload_data", 32'(bus.hs_din), 32'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 'h120, 0, 0, 'h024, 0, 1);
            tick();
        end
        drive(0, 0, 'h3F0, 0, 0, 'h024, 0, 1);
        repeat (3) tick();
        drive(0, 0, 'h3F0, 0, 0, 0, 0, 0);
        tick();

        // Reset in the middle of queued work.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 'h130, 0, 1, 'h050 + i, 'hD0 + i, 0);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        w0 = n_write_seen;
        drive(0, 0, 'h3F0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        check("rst_no_writes", 32'(n_write_seen - w0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 2**ADDR_W - 1),
                  $urandom_range(0, 255), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 2**ADDR_W - 1), $urandom_range(0, 255),
                  $urandom_range(0, 9) < 3);
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
